// File: rtl/loader_pkg.sv
// Shared types and framing constants for the boot-time instruction loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, W_LO, W_HI, CHK, DONE, ERR
    } ldr_state_t;

    localparam int LW             = 16;
    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 2;

    // States in which a load is in progress and stream bytes are consumed.
    function automatic logic is_busy(ldr_state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == W_LO) || (s == W_HI) || (s == CHK);
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Unpacks a length-prefixed byte stream into W-bit words, writes them to instruction
// memory from address 0, verifies an XOR checksum and then releases the core from reset.
module instr_loader
    import loader_pkg::*;
#(
    parameter int D = 10,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         im_wr_en,
    output logic [D-1:0] im_wr_addr,
    output logic [W-1:0] im_wr_data,
    output logic         core_reset,
    output logic         busy,
    output logic         load_done,
    output logic         err,
    output logic [2:0]   dbg_state
);

    localparam logic [LW-1:0] MAX_LEN = LW'(1) << D;

    ldr_state_t    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] len_full;
    logic [D:0]    count_q, count_d;
    logic [7:0]    chk_q, chk_d;
    logic [7:0]    lo_q, lo_d;
    logic          wr_en_d;
    logic [D-1:0]  wr_addr_d;
    logic [W-1:0]  wr_data_d;
    logic          accept;

    // Handshake: a byte moves only on a cycle where in_valid and in_ready are both high;
    // in_ready depends on state alone, so the producer never sees a combinational loop.
    assign in_ready  = is_busy(state_q);
    assign accept    = in_valid & in_ready;
    assign len_full  = {in_data, len_q[7:0]};
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q + (D+1)'(im_wr_en);
        chk_d     = chk_q;
        lo_d      = lo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = im_wr_addr;
        wr_data_d = im_wr_data;

        // The checksum byte itself is never folded into the running XOR.
        if (accept && state_q != CHK) begin
            chk_d = chk_q ^ in_data;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LEN_LO;
                    chk_d   = '0;
                    count_d = '0;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d   = {len_q[LW-1:8], in_data};
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full > MAX_LEN) begin
                        state_d = ERR;
                    end else if (len_full == '0) begin
                        state_d = CHK;
                    end else begin
                        state_d = W_LO;
                    end
                end
            end
            W_LO: begin
                if (accept) begin
                    lo_d    = in_data;
                    state_d = W_HI;
                end
            end
            W_HI: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[D-1:0];
                    wr_data_d = W'({in_data[0], lo_q});
                    // The previous word's write has always retired by now, so count_q is current.
                    state_d   = (LW'(count_q) + LW'(1) == len_q) ? CHK : W_LO;
                end
            end
            CHK: begin
                if (accept) begin
                    state_d = (in_data == chk_q) ? DONE : ERR;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            count_q    <= '0;
            chk_q      <= '0;
            lo_q       <= '0;
            im_wr_en   <= 1'b0;
            im_wr_addr <= '0;
            im_wr_data <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            count_q    <= count_d;
            chk_q      <= chk_d;
            lo_q       <= lo_d;
            im_wr_en   <= wr_en_d;
            im_wr_addr <= wr_addr_d;
            im_wr_data <= wr_data_d;
            core_reset <= (state_d != DONE);
            busy       <= is_busy(state_d);
            load_done  <= (state_d == DONE);
            err        <= (state_d == ERR);
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a driver streams bytes, a monitor checks every memory write.
module tb_instr_loader;
    import loader_pkg::*;

    logic       clk = 1'b0;
    logic       reset, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, im_wr_en, core_reset, busy, load_done, err;
    logic [9:0] im_wr_addr;
    logic [8:0] im_wr_data;
    logic [2:0] dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    int          writes_seen = 0;
    logic [9:0]  last_addr = '0;
    logic [18:0] exp_q[$];
    logic [8:0]  word_tb[1024];

    instr_loader #(.D(10), .W(9)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr),
        .im_wr_data(im_wr_data), .core_reset(core_reset), .busy(busy),
        .load_done(load_done), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected {addr, data}.
    always @(negedge clk) begin : monitor
        logic [18:0] e;
        if (im_wr_en === 1'b1) begin
            writes_seen++;
            last_addr = im_wr_addr;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         im_wr_addr, im_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({im_wr_addr, im_wr_data} !== e) begin
                    n_errors++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             im_wr_addr, im_wr_data, e[18:9], e[8:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int t;
        if (stall) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready=%b, expected 1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_state(input ldr_state_t target, input string name);
        int t;
        t = 0;
        while (dbg_state !== target && t < 20) begin
            @(negedge clk);
            t++;
        end
        check(name, dbg_state, target);
    endtask

    // Sends the length header and n words from word_tb; returns the XOR of all bytes sent.
    task automatic load_words(input int n, input logic [6:0] hi_upper, input bit stall,
                              output logic [7:0] chk);
        logic [15:0] len;
        logic [7:0]  lo, hi;
        len = 16'(n);
        chk = len[7:0] ^ len[15:8];
        send_byte(len[7:0], stall);
        send_byte(len[15:8], stall);
        for (int i = 0; i < n; i++) begin
            lo = word_tb[i][7:0];
            hi = {hi_upper, word_tb[i][8]};
            exp_q.push_back({10'(i), word_tb[i]});
            chk = chk ^ lo ^ hi;
            send_byte(lo, stall);
            send_byte(hi, stall);
        end
    endtask

    initial begin
        logic [7:0] chk;
        int         w0;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);

        check("rst_state", dbg_state, IDLE);
        check("rst_core_reset", core_reset, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", im_wr_en, 0);
        check("rst_wr_addr", im_wr_addr, 0);
        check("rst_wr_data", im_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_load_done", load_done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        reset = 1'b0;

        // Nominal load; the XOR of 03 00 2A 01 FF 00 10 00 is 0xC7.
        word_tb[0] = 9'h12A; word_tb[1] = 9'h0FF; word_tb[2] = 9'h010;
        pulse_start();
        check("start_state", dbg_state, LEN_LO);
        check("start_busy", busy, 1);
        check("start_in_ready", in_ready, 1);
        check("start_core_reset", core_reset, 1);
        w0 = writes_seen;
        load_words(3, 7'h00, 1'b0, chk);
        send_byte(8'hC7, 1'b0);
        idle_bus();
        wait_state(DONE, "nominal_done");
        check("nominal_load_done", load_done, 1);
        check("nominal_core_reset", core_reset, 0);
        check("nominal_busy", busy, 0);
        check("nominal_writes", writes_seen - w0, 3);

        // Reload from DONE, this time with a bad checksum byte.
        pulse_start();
        check("reload_core_reset", core_reset, 1);
        check("reload_state", dbg_state, LEN_LO);
        w0 = writes_seen;
        load_words(3, 7'h00, 1'b0, chk);
        send_byte(8'hC4, 1'b0);
        idle_bus();
        wait_state(ERR, "badchk_err_state");
        check("badchk_err", err, 1);
        check("badchk_core_reset", core_reset, 1);
        check("badchk_load_done", load_done, 0);
        check("badchk_writes", writes_seen - w0, 3);
        pulse_start();
        repeat (3) @(negedge clk);
        check("err_ignores_start", dbg_state, ERR);
        check("err_in_ready", in_ready, 0);
        pulse_reset();
        check("err_reset_state", dbg_state, IDLE);
        check("err_reset_err", err, 0);

        // Zero length: header then checksum 00, no writes.
        pulse_start();
        w0 = writes_seen;
        load_words(0, 7'h00, 1'b0, chk);
        send_byte(8'h00, 1'b0);
        idle_bus();
        wait_state(DONE, "zero_len_done");
        check("zero_len_writes", writes_seen - w0, 0);

        // Oversize length 0x0401 is rejected straight after the high length byte.
        pulse_start();
        w0 = writes_seen;
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("oversize_state", dbg_state, ERR);
        check("oversize_err", err, 1);
        repeat (3) @(negedge clk);
        check("oversize_writes", writes_seen - w0, 0);
        pulse_reset();

        // Stalled stream with junk in hi bits[7:1]; XOR of 03 00 2A FF FF FE 10 FE is 0x39.
        pulse_start();
        w0 = writes_seen;
        load_words(3, 7'h7F, 1'b1, chk);
        send_byte(8'h39, 1'b1);
        idle_bus();
        wait_state(DONE, "stall_done");
        check("stall_writes", writes_seen - w0, 3);

        // Full 1024-word image: last address 0x3FF, no wrap.
        for (int i = 0; i < 1024; i++) word_tb[i] = 9'((i * 37 + 5) & 511);
        pulse_start();
        w0 = writes_seen;
        load_words(1024, 7'h00, 1'b0, chk);
        send_byte(chk, 1'b0);
        idle_bus();
        wait_state(DONE, "full_done");
        check("full_last_addr", last_addr, 10'h3FF);
        check("full_writes", writes_seen - w0, 1024);

        // Reset mid-load right as word 1 is written.
        word_tb[0] = 9'h155; word_tb[1] = 9'h0AA;
        pulse_start();
        w0 = writes_seen;
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_q.push_back({10'd0, 9'h155});
        send_byte(8'h55, 1'b0);
        send_byte(8'h01, 1'b0);
        exp_q.push_back({10'd1, 9'h0AA});
        send_byte(8'hAA, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        in_data = 8'h77;
        reset   = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("midrst_state", dbg_state, IDLE);
        check("midrst_core_reset", core_reset, 1);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_wr_en", im_wr_en, 0);
        check("midrst_wr_addr", im_wr_addr, 0);
        check("midrst_wr_data", im_wr_data, 0);
        check("midrst_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("midrst_writes", writes_seen - w0, 2);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
